// File: rtl/dram_pkg.sv
// Shared types and default geometry for the DRAM initiator controller.
// The FSM state encoding lives here so the bench and any future blocks agree on it.
package dram_pkg;

  localparam int DEF_ADDR_W           = 3;
  localparam int DEF_DATA_W           = 8;
  localparam int DEF_REFRESH_INTERVAL = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RD_WAIT,
    REFRESH
  } state_t;

endpackage

// File: rtl/dram_host_if.sv
// Host-side request/response bundle: valid/ready request channel plus a one-cycle read response.
// The host drives through 'master'; the controller receives through 'slave'.
interface dram_host_if
  import dram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/dram_refresh_timer.sv
// Free-running refresh demand generator with a round-robin row pointer.
// A fresh expiry outranks the clear from a refresh being issued in the same cycle.
module dram_refresh_timer
  import dram_pkg::*;
#(
  parameter int ADDR_W           = DEF_ADDR_W,
  parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              refresh_done,
  output logic              ref_pend,
  output logic [ADDR_W-1:0] ref_ptr
);

  localparam int                CNT_W  = $clog2(REFRESH_INTERVAL);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_INTERVAL - 1);

  logic [CNT_W-1:0] ref_cnt;
  logic             expire;

  assign expire = (ref_cnt == '0);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt  <= RELOAD;
      ref_pend <= 1'b0;
      ref_ptr  <= '0;
    end else begin
      ref_cnt <= expire ? RELOAD : ref_cnt - CNT_W'(1);
      if (expire)
        ref_pend <= 1'b1;
      else if (refresh_done)
        ref_pend <= 1'b0;
      // Natural wrap of the ADDR_W-bit pointer walks every row in turn.
      if (refresh_done)
        ref_ptr <= ref_ptr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/dram_ctrl.sv
// Initiator-side controller for the single-port synchronous-read DRAM macro.
// Serialises host reads/writes onto the DRAM port and slots in periodic row refreshes.
module dram_ctrl
  import dram_pkg::*;
#(
  parameter int ADDR_W           = DEF_ADDR_W,
  parameter int DATA_W           = DEF_DATA_W,
  parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL
) (
  input  logic              clk,
  input  logic              rst_n,
  dram_host_if.slave        host,
  output logic              mem_we,
  output logic              mem_refresh,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  state_t            state, state_nx;
  logic              ref_pend;
  logic              refresh_done;
  logic              accept;
  logic [ADDR_W-1:0] ref_ptr;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  dram_refresh_timer #(
    .ADDR_W           (ADDR_W),
    .REFRESH_INTERVAL (REFRESH_INTERVAL)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .refresh_done (refresh_done),
    .ref_pend     (ref_pend),
    .ref_ptr      (ref_ptr)
  );

  // A pending refresh blocks new requests so it is issued on the next IDLE cycle.
  assign host.req_ready = (state == IDLE) && !ref_pend;
  assign accept         = host.req_valid && host.req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: the request holding registers are reset too, so mem_* never carry
  // stale values from before reset even in a cycle that ignores them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_we    <= host.req_we;
      lat_addr  <= host.req_addr;
      lat_wdata <= host.req_wdata;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path through it leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nx     = state;
    mem_we       = 1'b0;
    mem_refresh  = 1'b0;
    mem_addr     = '0;
    mem_din      = '0;
    refresh_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (ref_pend)    state_nx = REFRESH;
        else if (accept) state_nx = ISSUE;
      end
      REFRESH: begin
        mem_refresh  = 1'b1;
        mem_addr     = ref_ptr;
        refresh_done = 1'b1;
        state_nx     = IDLE;
      end
      ISSUE: begin
        mem_addr = lat_addr;
        mem_we   = lat_we;
        mem_din  = lat_wdata;
        state_nx = lat_we ? IDLE : RD_WAIT;
      end
      RD_WAIT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The DRAM read data is valid during RD_WAIT; capture it and pulse the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host.rsp_valid <= 1'b0;
      host.rsp_rdata <= '0;
    end else begin
      host.rsp_valid <= (state == RD_WAIT);
      if (state == RD_WAIT)
        host.rsp_rdata <= mem_dout;
    end
  end

endmodule

// File: tb/tb_dram_ctrl.sv
// Self-checking bench for dram_ctrl driving a behavioural synchronous-read DRAM.
// A vector table covers the main read/write function; hand sequences cover refresh and reset corners.
module tb_dram_ctrl;
  import dram_pkg::*;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int RI     = 8;

  logic              clk;
  logic              rst_n;
  logic              mem_we;
  logic              mem_refresh;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  dram_host_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) host ();

  dram_ctrl #(
    .ADDR_W           (ADDR_W),
    .DATA_W           (DATA_W),
    .REFRESH_INTERVAL (RI)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .host        (host),
    .mem_we      (mem_we),
    .mem_refresh (mem_refresh),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout)
  );

  // Behavioural DRAM: write on we, registered read of the presented address.
  logic [DATA_W-1:0] dram_mem [2**ADDR_W];
  always @(posedge clk) begin
    if (mem_we) dram_mem[mem_addr] <= mem_din;
    mem_dout <= dram_mem[mem_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks    = 0;
  int failures  = 0;
  int rsp_count = 0;
  int ref_seen  = 0;
  int lost      = 0;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                cyc;
  } sb_t;
  sb_t sb_q[$];
  sb_t sb_e;

  logic [DATA_W-1:0] model [2**ADDR_W];

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard and continuous monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      ref_seen = 0;
    end else begin
      if (host.rsp_valid) begin
        rsp_count++;
        check("rsp_expected", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          sb_e = sb_q.pop_front();
          check("rsp_data", 32'(host.rsp_rdata), 32'(sb_e.data));
          check("rsp_latency", 32'(cyc - sb_e.cyc), 32'd3);
        end
      end else if (sb_q.size() != 0 && cyc - sb_q[0].cyc > 3) begin
        check("rsp_missing", 32'(host.rsp_valid), 32'd1);
        void'(sb_q.pop_front());
      end
      if (host.req_valid && host.req_ready) begin
        if (host.req_we) model[host.req_addr] = host.req_wdata;
        else             sb_q.push_back('{data: model[host.req_addr], cyc: cyc});
      end
      if (mem_refresh) begin
        check("refresh_addr", 32'(mem_addr), 32'(ref_seen % (2**ADDR_W)));
        check("refresh_no_we", 32'(mem_we), 32'd0);
        ref_seen++;
      end
      // A demand arriving while the previous one is still unserviced would be lost.
      if (dut.u_timer.ref_cnt == '0 && dut.u_timer.ref_pend && !mem_refresh) lost++;
    end
  end

  task automatic do_req(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    bit ok = 1'b0;
    @(posedge clk); #1;
    host.req_valid = 1'b1;
    host.req_we    = we;
    host.req_addr  = addr;
    host.req_wdata = wdata;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (host.req_ready) begin ok = 1'b1; break; end
    end
    check("req_accepted", 32'(ok), 32'd1);
    @(posedge clk); #1;
    host.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit got);
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (host.rsp_valid) begin got = 1'b1; break; end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {mem_we, mem_refresh, 5'd0, mem_addr, mem_din, host.rsp_valid, 7'd0, host.rsp_rdata},
          32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit got;
    bit found;
    int n, prev, p, rel, rc0, rs0;

    for (int i = 0; i < 2**ADDR_W; i++) begin
      dram_mem[i] = '0;
      model[i]    = '0;
    end
    vecs[0] = '{1'b1, 3'd0, 8'hAA, 8'h00};
    vecs[1] = '{1'b1, 3'd1, 8'h55, 8'h00};
    vecs[2] = '{1'b0, 3'd0, 8'h00, 8'hAA};
    vecs[3] = '{1'b0, 3'd1, 8'h00, 8'h55};
    vecs[4] = '{1'b1, 3'd7, 8'h3C, 8'h00};
    vecs[5] = '{1'b0, 3'd7, 8'h00, 8'h3C};
    vecs[6] = '{1'b1, 3'd4, 8'hFF, 8'h00};
    vecs[7] = '{1'b1, 3'd4, 8'h00, 8'h00};
    vecs[8] = '{1'b0, 3'd4, 8'h00, 8'h00};
    vecs[9] = '{1'b0, 3'd2, 8'h00, 8'h00};

    rst_n          = 1'b0;
    host.req_valid = 1'b0;
    host.req_we    = 1'b0;
    host.req_addr  = '0;
    host.req_wdata = '0;

    // Reset state and the first cycle after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_outputs");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(host.req_ready), 32'd1);

    // Table-driven reads and writes.
    for (int i = 0; i < 10; i++) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      if (!vecs[i].we) begin
        wait_rsp(got);
        check($sformatf("vec%0d_rsp_seen", i), 32'(got), 32'd1);
        check($sformatf("vec%0d_rdata", i), 32'(host.rsp_rdata), 32'(vecs[i].exp));
      end
    end

    // Idle: refresh pulses every RI cycles, addresses walk and wrap.
    repeat (10) @(negedge clk);
    n = 0;
    prev = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (mem_refresh) begin
        if (prev >= 0) check("idle_refresh_spacing", 32'(cyc - prev), 32'(RI));
        prev = cyc;
        n++;
      end
    end
    check("idle_refresh_count", 32'(n), 32'd10);

    // Request raised in the cycle the demand registers: refresh goes first.
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_refresh) begin found = 1'b1; break; end
    end
    check("prio_sync_refresh", 32'(found), 32'd1);
    p = cyc;
    repeat (RI - 1) @(posedge clk);
    #1;
    host.req_valid = 1'b1;
    host.req_we    = 1'b0;
    host.req_addr  = 3'd1;
    @(negedge clk);
    check("prio_cycle", 32'(cyc - p), 32'(RI - 1));
    check("prio_ready_low", 32'(host.req_ready), 32'd0);
    @(negedge clk);
    check("prio_refresh_first", 32'(mem_refresh), 32'd1);
    check("prio_ready_low_refresh", 32'(host.req_ready), 32'd0);
    @(negedge clk);
    check("prio_accept_next_idle", 32'(host.req_ready), 32'd1);
    @(posedge clk); #1;
    host.req_valid = 1'b0;
    wait_rsp(got);
    check("prio_rsp_seen", 32'(got), 32'd1);
    check("prio_rdata", 32'(host.rsp_rdata), 32'h55);

    // Back-to-back reads for 100 cycles with refresh interleaving.
    for (int i = 0; i < 2**ADDR_W; i++)
      do_req(1'b1, ADDR_W'(i), DATA_W'(8'h11 * (i + 1)));
    rc0 = rsp_count;
    rs0 = ref_seen;
    @(posedge clk); #1;
    host.req_valid = 1'b1;
    host.req_we    = 1'b0;
    for (int i = 0; i < 100; i++) begin
      host.req_addr = ADDR_W'($urandom_range(0, 2**ADDR_W - 1));
      @(posedge clk); #1;
    end
    host.req_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("b2b_reads_done", 32'(rsp_count - rc0 >= 25), 32'd1);
    check("b2b_refresh_interleaved", 32'(ref_seen - rs0 >= 11), 32'd1);
    check("b2b_scoreboard_drained", 32'(sb_q.size()), 32'd0);

    // Reset during RD_WAIT: response dropped, timer restarts from its reset value.
    do_req(1'b0, 3'd3, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b0;
    rc0 = rsp_count;
    @(negedge clk);
    check_reset_outputs("midrun_reset_outputs");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rel = cyc;
    @(negedge clk);
    check("midrun_ready_after_release", 32'(host.req_ready), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_refresh) begin found = 1'b1; break; end
    end
    check("post_reset_refresh_seen", 32'(found), 32'd1);
    // ref_cnt counts 7..0 over cycles 0..7 after release, the demand registers at
    // the next edge, and REFRESH occupies the cycle after that.
    check("post_reset_refresh_cycle", 32'(cyc - rel), 32'(RI + 1));
    check("post_reset_refresh_addr", 32'(mem_addr), 32'd0);
    check("aborted_read_no_rsp", 32'(rsp_count - rc0), 32'd0);

    check("no_lost_refresh_demand", 32'(lost), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
